segment_writer: RTL and testbench

Avalon-MM master that drives the eight-digit seven-segment display peripheral from the watch datapath. On each update request it snapshots a 32-bit hex/BCD value, a decimal-point mask and a blink mask, and encodes each nibble to a segment pattern. It then issues nine single-beat writes: digit registers 0–7, then the blink register at address 8. It sits between the timekeeping logic and the display peripheral's slave port, so the timekeeping logic never handles bus timing.

---
 rtl/segment_writer.sv | 156 +++++++++++++++
 tb/tb_segment_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/segment_writer.sv
// Avalon-MM master that snapshots a display value and writes eight encoded
// seven-segment digits plus the blink mask to the display peripheral.
module segment_writer #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [7:0]  blink,
    input  logic        update,
    output logic        busy,
    output logic        done,
    output logic [3:0]  master_address,
    output logic        master_write,
    output logic [7:0]  master_writedata,
    input  logic        master_waitrequest
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        pending_q, pending_d;
    logic [31:0] val_q, val_d;
    logic [7:0]  dp_q, dp_d;
    logic [7:0]  blink_q, blink_d;
    logic        write_q, write_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        accept;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] n);
        case (n)
            4'h0: seg_encode = 7'h40;
            4'h1: seg_encode = 7'h79;
            4'h2: seg_encode = 7'h24;
            4'h3: seg_encode = 7'h30;
            4'h4: seg_encode = 7'h19;
            4'h5: seg_encode = 7'h12;
            4'h6: seg_encode = 7'h02;
            4'h7: seg_encode = 7'h78;
            4'h8: seg_encode = 7'h00;
            4'h9: seg_encode = 7'h10;
            4'hA: seg_encode = 7'h08;
            4'hB: seg_encode = 7'h03;
            4'hC: seg_encode = 7'h46;
            4'hD: seg_encode = 7'h21;
            4'hE: seg_encode = 7'h06;
            default: seg_encode = 7'h0E;
        endcase
    endfunction

    // Digit i takes the i-th nibble from the top and dp bit 7-i.
    function automatic logic [7:0] digit_byte(input logic [31:0] v, input logic [7:0] d,
                                              input logic [3:0] i);
        logic [31:0] vs;
        logic [7:0]  ds;
        logic [7:0]  b;
        vs = v << {i, 2'b00};
        ds = d << i;
        b  = {~ds[7], seg_encode(vs[31:28])};
        if (!SEG_ACTIVE_LOW) begin
            b = ~b;
        end
        return b;
    endfunction

    assign accept = (state_q == WRITE) && !master_waitrequest;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        val_d     = val_q;
        dp_d      = dp_q;
        blink_d   = blink_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (update || pending_q) begin
                    state_d   = WRITE;
                    val_d     = value;
                    dp_d      = dp;
                    blink_d   = blink;
                    idx_d     = 4'd0;
                    pending_d = 1'b0;
                end
            end
            default: begin
                if (update) begin
                    pending_d = 1'b1;
                end
                if (accept) begin
                    if (idx_q == 4'd8) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
        endcase

        // Outputs are precomputed from the next state so they leave a register.
        write_d = (state_d == WRITE);
        busy_d  = (state_d == WRITE);
        addr_d  = (state_d == WRITE) ? idx_d : 4'd0;
        if (state_d != WRITE) begin
            data_d = 8'h00;
        end else if (idx_d == 4'd8) begin
            data_d = blink_d;
        end else begin
            data_d = digit_byte(val_d, dp_d, idx_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            pending_q <= 1'b0;
            val_q     <= 32'd0;
            dp_q      <= 8'd0;
            blink_q   <= 8'd0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= 4'd0;
            data_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            val_q     <= val_d;
            dp_q      <= dp_d;
            blink_q   <= blink_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign master_write     = write_q;
    assign master_address   = addr_q;
    assign master_writedata = data_q;

endmodule

// File: tb/tb_segment_writer.sv
// Directed bench for segment_writer: table-driven encode vectors plus stall,
// queued-update and mid-sequence reset sequences on both segment polarities.
module tb_segment_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        update = 1'b0;
    logic        waitrequest = 1'b0;
    logic [31:0] value = 32'd0;
    logic [7:0]  dp = 8'd0;
    logic [7:0]  blink = 8'd0;

    logic        busy1, done1, write1, busy2, done2, write2;
    logic [3:0]  addr1, addr2;
    logic [7:0]  data1, data2;

    int checks = 0;
    int failures = 0;

    logic [3:0] la1[$];
    logic [7:0] ld1[$];
    logic [3:0] la2[$];
    logic [7:0] ld2[$];

    segment_writer #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .blink(blink),
        .update(update), .busy(busy1), .done(done1), .master_address(addr1),
        .master_write(write1), .master_writedata(data1), .master_waitrequest(waitrequest)
    );

    segment_writer #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .blink(blink),
        .update(update), .busy(busy2), .done(done2), .master_address(addr2),
        .master_write(write2), .master_writedata(data2), .master_waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    // Record every write that will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (!reset && write1 && !waitrequest) begin
            la1.push_back(addr1);
            ld1.push_back(data1);
        end
        if (!reset && write2 && !waitrequest) begin
            la2.push_back(addr2);
            ld2.push_back(data2);
        end
    end

    typedef struct {
        logic [31:0]      v;
        logic [7:0]       d;
        logic [7:0]       b;
        logic [0:8][7:0]  e1;
        logic [0:8][7:0]  e2;
    } vec_t;

    vec_t vt[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b,
                       input int stall_n, input int upd_a, input int upd_b,
                       input logic [31:0] v2, input int ncyc,
                       output int done_n, output int done_k, output int busy_n,
                       output int a4_n, output int a4_diff, output int restart_k);
        int stall_left;
        logic [7:0] a4_data;
        done_n = 0; done_k = 0; busy_n = 0; a4_n = 0; a4_diff = 0; restart_k = 0;
        stall_left = stall_n;
        a4_data = 8'd0;
        la1.delete(); ld1.delete(); la2.delete(); ld2.delete();
        value = v; dp = d; blink = b; update = 1'b1;
        @(posedge clk); #1;
        update = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (write1 && addr1 == 4'd4) begin
                if (a4_n == 0) a4_data = data1;
                else if (data1 !== a4_data) a4_diff++;
                a4_n++;
            end
            if (busy1) busy_n++;
            if (done1) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
            if (done_n > 0 && !done1 && write1 && restart_k == 0) restart_k = k;
            if (k == upd_a || k == upd_b) begin
                update = 1'b1;
                value = v2;
            end else begin
                update = 1'b0;
            end
            if (stall_left > 0 && write1 && addr1 == 4'd4) begin
                waitrequest = 1'b1;
                stall_left--;
            end else begin
                waitrequest = 1'b0;
            end
            @(posedge clk); #1;
        end
        update = 1'b0;
        waitrequest = 1'b0;
    endtask

    task automatic check_log(input string tag, input logic [0:8][7:0] e1, input logic [0:8][7:0] e2);
        chk({tag, " lo count"}, la1.size(), 9);
        chk({tag, " hi count"}, la2.size(), 9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("%s lo write%0d", tag, i),
                (i < la1.size()) ? {20'd0, la1[i], ld1[i]} : 32'hxxxxxxxx,
                {20'd0, i[3:0], e1[i]});
            chk($sformatf("%s hi write%0d", tag, i),
                (i < la2.size()) ? {20'd0, la2[i], ld2[i]} : 32'hxxxxxxxx,
                {20'd0, i[3:0], e2[i]});
        end
    endtask

    initial begin
        int dn, dk, bn, a4n, a4d, rk, wcnt;
        bit found;

        vt[0].v = 32'h12345678; vt[0].d = 8'h00; vt[0].b = 8'h00;
        vt[0].e1 = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h00};
        vt[0].e2 = {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h00};
        vt[1].v = 32'h9ABCDEF0; vt[1].d = 8'h81; vt[1].b = 8'h0F;
        vt[1].e1 = {8'h10, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E, 8'h40, 8'h0F};
        vt[1].e2 = {8'hEF, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'hBF, 8'h0F};
        vt[2].v = 32'h00000000; vt[2].d = 8'h80; vt[2].b = 8'hFF;
        vt[2].e1 = {8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF};
        vt[2].e2 = {8'hBF, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'hFF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {busy1, busy2}, 2'b00);
        chk("reset done", {done1, done2}, 2'b00);
        chk("reset write", {write1, write2}, 2'b00);
        chk("reset addr", {addr1, addr2}, 8'h00);
        chk("reset data", {data1, data2}, 16'h0000);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle write", write1, 1'b0);

        // Encoding vectors, no stall
        for (int r = 0; r < 3; r++) begin
            run(vt[r].v, vt[r].d, vt[r].b, 0, 0, 0, vt[r].v, 14, dn, dk, bn, a4n, a4d, rk);
            chk($sformatf("vec%0d done cycle", r), dk, 10);
            chk($sformatf("vec%0d done pulses", r), dn, 1);
            chk($sformatf("vec%0d busy cycles", r), bn, 9);
            check_log($sformatf("vec%0d", r), vt[r].e1, vt[r].e2);
        end

        // Three-cycle stall on address 4
        run(32'h12345678, 8'h00, 8'h00, 3, 0, 0, 32'h12345678, 18, dn, dk, bn, a4n, a4d, rk);
        chk("stall done cycle", dk, 13);
        chk("stall busy cycles", bn, 12);
        chk("stall addr4 cycles", a4n, 4);
        chk("stall addr4 data changes", a4d, 0);
        check_log("stall", vt[0].e1, vt[0].e2);

        // Two updates during busy collapse into one queued sequence
        run(32'h11111111, 8'h00, 8'h00, 0, 3, 6, 32'h22222222, 40, dn, dk, bn, a4n, a4d, rk);
        chk("queued done pulses", dn, 2);
        chk("queued first done", dk, 10);
        chk("queued restart cycle", rk, 11);
        chk("queued write count", la1.size(), 18);
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("queued write%0d", i),
                (i < la1.size()) ? {20'd0, la1[i], ld1[i]} : 32'hxxxxxxxx,
                {20'd0, 4'(i % 9), (i % 9 == 8) ? 8'h00 : ((i < 9) ? 8'hF9 : 8'hA4)});
        end

        // Update on the same edge as the final accept
        run(32'h12345678, 8'h00, 8'h00, 0, 9, 0, 32'h12345678, 30, dn, dk, bn, a4n, a4d, rk);
        chk("lastedge done pulses", dn, 2);
        chk("lastedge restart cycle", rk, 11);

        // Reset asserted during a stall at address 3, with a pending update
        la1.delete(); ld1.delete(); la2.delete(); ld2.delete();
        value = 32'h12345678; dp = 8'h00; blink = 8'h00; update = 1'b1;
        @(posedge clk); #1;
        update = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            if (k == 2) update = 1'b1; else update = 1'b0;
            if (write1 && addr1 == 4'd3) begin
                found = 1'b1;
                waitrequest = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        update = 1'b0;
        chk("reset test reached addr3", found, 1'b1);
        @(posedge clk); #1;
        chk("stalled addr3 held", {write1, addr1}, {1'b1, 4'd3});
        #2;
        reset = 1'b1;
        #1;
        chk("async reset write", {write1, write2}, 2'b00);
        chk("async reset busy", {busy1, busy2}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        waitrequest = 1'b0;
        la1.delete(); ld1.delete(); la2.delete(); ld2.delete();
        wcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (write1 || busy1 || write2) wcnt++;
            @(posedge clk); #1;
        end
        chk("post reset activity", wcnt, 0);
        chk("post reset writes logged", la1.size() + la2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
